// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scan controller: walks digits 0..3 at a fixed slot rate and
// swaps in new display contents only at frame boundaries (or while idle).
module seg_scan_ctrl #(
    parameter int SCAN_DIV  = 50000,
    parameter int BLANK_CYC = 16
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    input  logic        enable,
    input  logic        upd_valid,
    output logic        upd_ready,
    input  logic [15:0] upd_data,
    input  logic [3:0]  upd_mask,
    input  logic [3:0]  upd_dp,
    output logic [2:0]  bit_disp,
    output logic [3:0]  data_disp,
    output logic        dp,
    output logic        blank,
    output logic        frame_done
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] SLOT_LAST = CW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] SHOW_LEN  = CW'(SCAN_DIV - BLANK_CYC);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHOW,
        ST_BLANK
    } state_t;

    state_t        state_reg, state_next;
    logic [CW-1:0] cnt_reg, cnt_next, cnt_inc;
    logic [1:0]    digit_reg, digit_next;

    logic [15:0]   act_data_reg, act_data_next;
    logic [3:0]    act_mask_reg, act_mask_next;
    logic [3:0]    act_dp_reg, act_dp_next;
    logic [15:0]   pend_data_reg, pend_data_next;
    logic [3:0]    pend_mask_reg, pend_mask_next;
    logic [3:0]    pend_dp_reg, pend_dp_next;
    logic          full_reg, full_next;

    logic          upd_ready_reg, upd_ready_next;
    logic [2:0]    bit_disp_reg, bit_disp_next;
    logic [3:0]    data_disp_reg, data_disp_next;
    logic          dp_reg, dp_next;
    logic          blank_reg, blank_next;
    logic          frame_done_reg, frame_done_next;

    logic          capture, apply;
    logic [3:0]    nib_arr [4];

    // Nibble view of the active set after any apply in this cycle
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_nib
            assign nib_arr[gi] = act_data_next[4*gi +: 4];
        end
    endgenerate

    assign cnt_inc = cnt_reg + 1'b1;

    // Slot sequencing: one counter spans SHOW and BLANK, so every slot is SCAN_DIV cycles
    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        digit_next = digit_reg;
        case (state_reg)
            ST_IDLE: begin
                cnt_next   = '0;
                digit_next = '0;
                if (enable) begin
                    state_next = ST_SHOW;
                end
            end
            default: begin
                if (!enable) begin
                    state_next = ST_IDLE;
                    cnt_next   = '0;
                    digit_next = '0;
                end else if (cnt_reg == SLOT_LAST) begin
                    state_next = ST_SHOW;
                    cnt_next   = '0;
                    digit_next = digit_reg + 2'd1;
                end else begin
                    cnt_next = cnt_inc;
                    if ((BLANK_CYC > 0) && (cnt_inc == SHOW_LEN)) begin
                        state_next = ST_BLANK;
                    end
                end
            end
        endcase
    end

    // Shadow register handshake; apply only happens with full set, so it never overlaps a capture
    always_comb begin
        capture        = upd_valid & ~full_reg;
        apply          = full_reg & (frame_done_reg | (state_reg == ST_IDLE));
        pend_data_next = pend_data_reg;
        pend_mask_next = pend_mask_reg;
        pend_dp_next   = pend_dp_reg;
        full_next      = full_reg;
        act_data_next  = act_data_reg;
        act_mask_next  = act_mask_reg;
        act_dp_next    = act_dp_reg;
        if (apply) begin
            act_data_next = pend_data_reg;
            act_mask_next = pend_mask_reg;
            act_dp_next   = pend_dp_reg;
            full_next     = 1'b0;
        end
        if (capture) begin
            pend_data_next = upd_data;
            pend_mask_next = upd_mask;
            pend_dp_next   = upd_dp;
            full_next      = 1'b1;
        end
        upd_ready_next = ~full_next;
    end

    // Registered display outputs, computed from the post-edge state and active set
    always_comb begin
        bit_disp_next   = bit_disp_reg;
        data_disp_next  = data_disp_reg;
        dp_next         = dp_reg;
        blank_next      = 1'b1;
        frame_done_next = (state_next != ST_IDLE) && (digit_next == 2'd3) && (cnt_next == SLOT_LAST);
        case (state_next)
            ST_IDLE: begin
                bit_disp_next  = 3'd0;
                data_disp_next = 4'd0;
                dp_next        = 1'b0;
            end
            ST_SHOW: begin
                bit_disp_next  = {1'b0, digit_next};
                data_disp_next = nib_arr[digit_next];
                dp_next        = act_dp_next[digit_next];
                blank_next     = ~act_mask_next[digit_next];
            end
            default: begin
                blank_next = 1'b1;
            end
        endcase
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            digit_reg      <= '0;
            act_data_reg   <= '0;
            act_mask_reg   <= '0;
            act_dp_reg     <= '0;
            pend_data_reg  <= '0;
            pend_mask_reg  <= '0;
            pend_dp_reg    <= '0;
            full_reg       <= 1'b0;
            upd_ready_reg  <= 1'b1;
            bit_disp_reg   <= '0;
            data_disp_reg  <= '0;
            dp_reg         <= 1'b0;
            blank_reg      <= 1'b1;
            frame_done_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            digit_reg      <= digit_next;
            act_data_reg   <= act_data_next;
            act_mask_reg   <= act_mask_next;
            act_dp_reg     <= act_dp_next;
            pend_data_reg  <= pend_data_next;
            pend_mask_reg  <= pend_mask_next;
            pend_dp_reg    <= pend_dp_next;
            full_reg       <= full_next;
            upd_ready_reg  <= upd_ready_next;
            bit_disp_reg   <= bit_disp_next;
            data_disp_reg  <= data_disp_next;
            dp_reg         <= dp_next;
            blank_reg      <= blank_next;
            frame_done_reg <= frame_done_next;
        end
    end

    assign upd_ready  = upd_ready_reg;
    assign bit_disp   = bit_disp_reg;
    assign data_disp  = data_disp_reg;
    assign dp         = dp_reg;
    assign blank      = blank_reg;
    assign frame_done = frame_done_reg;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl: table of frame vectors plus hand-written sequences
// for tear-free updates, back-to-back updates, enable drop and mid-frame reset.
module tb_seg_scan_ctrl;

    logic        HCLK = 1'b0;
    logic        HRESETn;
    logic        enable;
    logic        upd_valid;
    logic [15:0] upd_data;
    logic [3:0]  upd_mask;
    logic [3:0]  upd_dp;

    logic        upd_ready, dp, blank, frame_done;
    logic [2:0]  bit_disp;
    logic [3:0]  data_disp;

    logic        upd_ready_b0, dp_b0, blank_b0, frame_done_b0;
    logic [2:0]  bit_disp_b0;
    logic [3:0]  data_disp_b0;

    int total = 0;
    int bad   = 0;

    always #5 HCLK = ~HCLK;

    seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(2)) u_dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_data(upd_data), .upd_mask(upd_mask), .upd_dp(upd_dp),
        .bit_disp(bit_disp), .data_disp(data_disp), .dp(dp),
        .blank(blank), .frame_done(frame_done)
    );

    seg_scan_ctrl #(.SCAN_DIV(8), .BLANK_CYC(0)) u_dut_b0 (
        .HCLK(HCLK), .HRESETn(HRESETn), .enable(enable),
        .upd_valid(upd_valid), .upd_ready(upd_ready_b0),
        .upd_data(upd_data), .upd_mask(upd_mask), .upd_dp(upd_dp),
        .bit_disp(bit_disp_b0), .data_disp(data_disp_b0), .dp(dp_b0),
        .blank(blank_b0), .frame_done(frame_done_b0)
    );

    typedef struct {
        logic [15:0] data;
        logic [3:0]  mask;
        logic [3:0]  dpv;
        logic [3:0]  exp_nib [4];
        logic [3:0]  exp_lit;
        logic [3:0]  exp_dp;
    } vec_t;

    vec_t vecs [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge HCLK);
        #1;
    endtask

    task automatic chk_disp(input string tag, input int b, input int d, input int bl, input int fd);
        chk({tag, " bit_disp"},   32'(bit_disp),   32'(b));
        chk({tag, " data_disp"},  32'(data_disp),  32'(d));
        chk({tag, " blank"},      32'(blank),      32'(bl));
        chk({tag, " frame_done"}, 32'(frame_done), 32'(fd));
    endtask

    // Load a vector through the IDLE apply path, then check one full 32-cycle frame
    task automatic load_and_scan(input int idx);
        vec_t v;
        int   d, ph;
        logic exp_blank;
        v = vecs[idx];
        enable = 1'b0;
        step();
        upd_valid = 1'b1;
        upd_data  = v.data;
        upd_mask  = v.mask;
        upd_dp    = v.dpv;
        step();
        upd_valid = 1'b0;
        chk($sformatf("v%0d ready_after_capture", idx), 32'(upd_ready), 32'd0);
        step();
        chk($sformatf("v%0d ready_after_idle_apply", idx), 32'(upd_ready), 32'd1);
        enable = 1'b1;
        step();
        for (int c = 0; c < 32; c++) begin
            d  = c / 8;
            ph = c % 8;
            exp_blank = (ph >= 6) || !v.exp_lit[d];
            chk($sformatf("v%0d c%0d bit_disp", idx, c), 32'(bit_disp), 32'(d));
            chk($sformatf("v%0d c%0d data_disp", idx, c), 32'(data_disp), 32'(v.exp_nib[d]));
            chk($sformatf("v%0d c%0d dp", idx, c), 32'(dp), 32'(v.exp_dp[d]));
            chk($sformatf("v%0d c%0d blank", idx, c), 32'(blank), 32'(exp_blank));
            chk($sformatf("v%0d c%0d frame_done", idx, c), 32'(frame_done), 32'(c == 31));
            chk($sformatf("v%0d c%0d upd_ready", idx, c), 32'(upd_ready), 32'd1);
            chk($sformatf("v%0d c%0d b0 bit_disp", idx, c), 32'(bit_disp_b0), 32'(d));
            chk($sformatf("v%0d c%0d b0 data_disp", idx, c), 32'(data_disp_b0), 32'(v.exp_nib[d]));
            chk($sformatf("v%0d c%0d b0 blank", idx, c), 32'(blank_b0), 32'(!v.exp_lit[d]));
            chk($sformatf("v%0d c%0d b0 frame_done", idx, c), 32'(frame_done_b0), 32'(c == 31));
            step();
        end
        $display("vector %0d data=%h mask=%h dp=%h scanned (total=%0d bad=%0d)",
                 idx, v.data, v.mask, v.dpv, total, bad);
    endtask

    initial begin
        vecs[0] = '{data: 16'h3A71, mask: 4'hF, dpv: 4'h2,
                    exp_nib: '{4'h1, 4'h7, 4'hA, 4'h3}, exp_lit: 4'b1111, exp_dp: 4'b0010};
        vecs[1] = '{data: 16'hBEEF, mask: 4'h5, dpv: 4'h8,
                    exp_nib: '{4'hF, 4'hE, 4'hE, 4'hB}, exp_lit: 4'b0101, exp_dp: 4'b1000};
        vecs[2] = '{data: 16'h9C40, mask: 4'hA, dpv: 4'h5,
                    exp_nib: '{4'h0, 4'h4, 4'hC, 4'h9}, exp_lit: 4'b1010, exp_dp: 4'b0101};
        vecs[3] = '{data: 16'h0000, mask: 4'h0, dpv: 4'hF,
                    exp_nib: '{4'h0, 4'h0, 4'h0, 4'h0}, exp_lit: 4'b0000, exp_dp: 4'b1111};

        HRESETn   = 1'b0;
        enable    = 1'b0;
        upd_valid = 1'b0;
        upd_data  = '0;
        upd_mask  = '0;
        upd_dp    = '0;
        step();
        chk_disp("reset", 0, 0, 1, 0);
        chk("reset dp", 32'(dp), 32'd0);
        chk("reset upd_ready", 32'(upd_ready), 32'd1);
        HRESETn = 1'b1;
        step();
        chk_disp("idle", 0, 0, 1, 0);
        $display("reset checked (total=%0d bad=%0d)", total, bad);

        for (int i = 0; i < 4; i++) begin
            load_and_scan(i);
        end

        // Tear-free update: request mid digit 2, new value only from next frame's digit 0
        load_and_scan(0);
        repeat (18) step();
        upd_valid = 1'b1;
        upd_data  = 16'hFFFF;
        upd_mask  = 4'hF;
        upd_dp    = 4'h0;
        step();
        upd_valid = 1'b0;
        chk("tear ready_low", 32'(upd_ready), 32'd0);
        chk_disp("tear c19", 2, 4'hA, 0, 0);
        repeat (5) step();
        chk_disp("tear c24", 3, 4'h3, 0, 0);
        chk("tear c24 ready", 32'(upd_ready), 32'd0);
        repeat (7) step();
        chk_disp("tear c31", 3, 4'h3, 1, 1);
        chk("tear c31 ready", 32'(upd_ready), 32'd0);
        step();
        chk_disp("tear new_frame", 0, 4'hF, 0, 0);
        chk("tear new_frame ready", 32'(upd_ready), 32'd1);
        $display("tear-free update sequence done (total=%0d bad=%0d)", total, bad);

        // Back-to-back: 0x1111 accepted, 0x2222 waits until ready rises after the boundary
        upd_valid = 1'b1;
        upd_data  = 16'h1111;
        step();
        chk("b2b first_accept ready", 32'(upd_ready), 32'd0);
        chk_disp("b2b c1", 0, 4'hF, 0, 0);
        upd_data = 16'h2222;
        repeat (30) step();
        chk_disp("b2b c31", 3, 4'hF, 1, 1);
        chk("b2b c31 ready", 32'(upd_ready), 32'd0);
        step();
        chk_disp("b2b f1 c0", 0, 4'h1, 0, 0);
        chk("b2b f1 c0 ready", 32'(upd_ready), 32'd1);
        step();
        upd_valid = 1'b0;
        chk("b2b second_accept ready", 32'(upd_ready), 32'd0);
        repeat (7) step();
        chk_disp("b2b f1 c8", 1, 4'h1, 0, 0);
        repeat (23) step();
        chk_disp("b2b f1 c31", 3, 4'h1, 1, 1);
        step();
        chk_disp("b2b f2 c0", 0, 4'h2, 0, 0);
        chk("b2b f2 c0 ready", 32'(upd_ready), 32'd1);
        $display("back-to-back update sequence done (total=%0d bad=%0d)", total, bad);

        // Enable drop in digit 1 with an update pending: IDLE, no frame_done, apply in IDLE
        upd_valid = 1'b1;
        upd_data  = 16'h5555;
        step();
        upd_valid = 1'b0;
        chk("endrop pending ready", 32'(upd_ready), 32'd0);
        repeat (9) step();
        chk_disp("endrop c10", 1, 4'h2, 0, 0);
        enable = 1'b0;
        step();
        chk_disp("endrop idle1", 0, 0, 1, 0);
        chk("endrop idle1 ready", 32'(upd_ready), 32'd0);
        step();
        chk_disp("endrop idle2", 0, 0, 1, 0);
        chk("endrop idle2 ready", 32'(upd_ready), 32'd1);
        enable = 1'b1;
        step();
        chk_disp("endrop restart", 0, 4'h5, 0, 0);
        $display("enable drop sequence done (total=%0d bad=%0d)", total, bad);

        // Reset mid-SHOW with an update pending: reset values, pending discarded
        step();
        upd_valid = 1'b1;
        upd_data  = 16'h7777;
        step();
        upd_valid = 1'b0;
        chk("rst pending ready", 32'(upd_ready), 32'd0);
        HRESETn = 1'b0;
        step();
        HRESETn = 1'b1;
        chk_disp("rst after", 0, 0, 1, 0);
        chk("rst after dp", 32'(dp), 32'd0);
        chk("rst after ready", 32'(upd_ready), 32'd1);
        step();
        chk_disp("rst reenable", 0, 0, 1, 0);
        chk("rst reenable ready", 32'(upd_ready), 32'd1);
        $display("mid-frame reset sequence done (total=%0d bad=%0d)", total, bad);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
